// File: rtl/echo_sequencer.sv
// Bypass/enable sequencer for the delay-line echo: flushes stale audio, then ramps tap
// attenuation in and out so switching the effect never clicks.
module echo_sequencer #(
    parameter int DEPTH        = 128,
    parameter int ATTEN_W      = 4,
    parameter int RAMP_SAMPLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic               effect_on,
    input  logic [ATTEN_W-1:0] target_atten,
    output logic               shift_en,
    output logic               clear,
    output logic               bypass,
    output logic [ATTEN_W-1:0] atten,
    output logic               busy
);

    localparam int RC_W = $clog2(RAMP_SAMPLES) + 1;
    localparam int FC_W = $clog2(DEPTH) + 1;
    localparam logic [ATTEN_W-1:0] MAX_ATTEN  = '1;
    localparam logic [RC_W-1:0]    RAMP_LAST  = RC_W'(RAMP_SAMPLES - 1);
    localparam logic [FC_W-1:0]    FLUSH_LAST = FC_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_BYPASS,
        S_FLUSH,
        S_RAMP_UP,
        S_ACTIVE,
        S_RAMP_DOWN
    } state_t;

    state_t             state_q, state_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [RC_W-1:0]    ramp_cnt_q, ramp_cnt_d;
    logic [ATTEN_W-1:0] atten_q, atten_d;
    logic               shift_en_q, shift_en_d;
    logic               clear_q, clear_d;
    logic               bypass_q, bypass_d;
    logic               busy_q, busy_d;

    logic               do_count;
    logic               in_stream;
    logic [ATTEN_W-1:0] ramp_goal;
    logic [ATTEN_W-1:0] atten_step;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ramp_cnt_d  = ramp_cnt_q;
        atten_d     = atten_q;
        do_count    = 1'b0;
        in_stream   = (state_q == S_RAMP_UP) || (state_q == S_ACTIVE) ||
                      (state_q == S_RAMP_DOWN);
        ramp_goal   = (state_q == S_RAMP_DOWN) ? MAX_ATTEN : target_atten;
        atten_step  = (atten_q > ramp_goal) ? atten_q - ATTEN_W'(1)
                                            : atten_q + ATTEN_W'(1);

        // A sample arriving on an entry into a streaming state counts as that state's first.
        case (state_q)
            S_BYPASS: begin
                atten_d    = MAX_ATTEN;
                ramp_cnt_d = '0;
                if (effect_on) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            S_FLUSH: begin
                if (!effect_on) begin
                    state_d = S_BYPASS;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    state_d    = S_RAMP_UP;
                    ramp_cnt_d = RC_W'(sample_valid);
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            S_RAMP_UP: begin
                if (!effect_on) begin
                    state_d    = S_RAMP_DOWN;
                    ramp_cnt_d = RC_W'(sample_valid);
                end else if (atten_q == target_atten) begin
                    state_d    = S_ACTIVE;
                    ramp_cnt_d = RC_W'(sample_valid);
                end else begin
                    do_count = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!effect_on) begin
                    state_d    = S_RAMP_DOWN;
                    ramp_cnt_d = RC_W'(sample_valid);
                end else if (atten_q == target_atten) begin
                    ramp_cnt_d = '0;
                end else begin
                    do_count = 1'b1;
                end
            end
            S_RAMP_DOWN: begin
                if (effect_on) begin
                    state_d    = S_RAMP_UP;
                    ramp_cnt_d = RC_W'(sample_valid);
                end else if (atten_q == MAX_ATTEN) begin
                    state_d    = S_BYPASS;
                    ramp_cnt_d = '0;
                end else begin
                    do_count = 1'b1;
                end
            end
            default: begin
                state_d = S_BYPASS;
            end
        endcase

        if (do_count && sample_valid) begin
            if (ramp_cnt_q >= RAMP_LAST) begin
                ramp_cnt_d = '0;
                atten_d    = atten_step;
            end else begin
                ramp_cnt_d = ramp_cnt_q + RC_W'(1);
            end
        end

        // Streaming strobes lag sample_valid by one cycle; the flush strobes every cycle.
        shift_en_d = (state_d == S_FLUSH) || (sample_valid && in_stream);
        clear_d    = (state_d == S_FLUSH);
        bypass_d   = (state_d == S_BYPASS) || (state_d == S_FLUSH);
        busy_d     = (state_d == S_FLUSH) || (state_d == S_RAMP_UP) ||
                     (state_d == S_RAMP_DOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BYPASS;
            flush_cnt_q <= '0;
            ramp_cnt_q  <= '0;
            atten_q     <= MAX_ATTEN;
            shift_en_q  <= 1'b0;
            clear_q     <= 1'b0;
            bypass_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ramp_cnt_q  <= ramp_cnt_d;
            atten_q     <= atten_d;
            shift_en_q  <= shift_en_d;
            clear_q     <= clear_d;
            bypass_q    <= bypass_d;
            busy_q      <= busy_d;
        end
    end

    assign shift_en = shift_en_q;
    assign clear    = clear_q;
    assign bypass   = bypass_q;
    assign atten    = atten_q;
    assign busy     = busy_q;

endmodule
